// File: rtl/usr_shift_sequencer.sv
// Sequences an external universal shift register: load, paced serial shift, result return.
// Latency: done_valid 2 + n*(div+2) cycles after accept; start held off outside IDLE, result held until done_ready.
module usr_shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             dir,
  input  logic [CNT_W-1:0] bit_count,
  input  logic [DIV_W-1:0] div,
  output logic [1:0]       usr_mode,
  output logic [WIDTH-1:0] usr_parallel_in,
  output logic             usr_serial_left,
  output logic             usr_serial_right,
  input  logic [WIDTH-1:0] usr_q,
  input  logic             sdi,
  output logic             sdo,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] done_data
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_SHIFT, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data_r;
  logic             dir_r;
  logic [DIV_W-1:0] div_r, div_cnt, div_cnt_nxt;
  logic [CNT_W-1:0] bits_r, bits_nxt;
  logic             accept;

  assign accept           = (state == S_IDLE) && start_valid;
  assign busy             = (state != S_IDLE);
  assign usr_serial_left  = sdi;
  assign usr_serial_right = sdi;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      data_r  <= '0;
      dir_r   <= 1'b0;
      div_r   <= '0;
      div_cnt <= '0;
      bits_r  <= '0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_cnt_nxt;
      bits_r  <= bits_nxt;
      if (accept) begin
        data_r <= tx_data;
        dir_r  <= dir;
        div_r  <= div;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    div_cnt_nxt     = div_cnt;
    bits_nxt        = bits_r;
    start_ready     = 1'b0;
    usr_mode        = 2'b00;
    usr_parallel_in = '0;
    sdo             = 1'b0;
    bit_strobe      = 1'b0;
    done_valid      = 1'b0;
    done_data       = '0;
    case (state)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          state_nxt = S_LOAD;
          bits_nxt  = (bit_count == '0) ? CNT_W'(WIDTH) : bit_count;
        end
      end
      S_LOAD: begin
        usr_mode        = 2'b11;
        usr_parallel_in = data_r;
        div_cnt_nxt     = div_r;
        state_nxt       = S_WAIT;
      end
      S_WAIT: begin
        sdo = dir_r ? usr_q[0] : usr_q[WIDTH-1];
        if (div_cnt == '0) state_nxt = S_SHIFT;
        else               div_cnt_nxt = div_cnt - DIV_W'(1);
      end
      S_SHIFT: begin
        usr_mode   = dir_r ? 2'b10 : 2'b01;
        bit_strobe = 1'b1;
        sdo        = dir_r ? usr_q[0] : usr_q[WIDTH-1];
        bits_nxt   = bits_r - CNT_W'(1);
        if (bits_r == CNT_W'(1)) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt   = S_WAIT;
          div_cnt_nxt = div_r;
        end
      end
      S_DONE: begin
        // The register sits in hold here, so usr_q is a stable result.
        done_valid = 1'b1;
        done_data  = usr_q;
        if (done_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Bench for usr_shift_sequencer with a behavioural 8-bit universal shift register attached;
// expected strobes and results are queued per request and matched by a monitor.
module tb_usr_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] tx_data;
  logic       dir;
  logic [3:0] bit_count;
  logic [7:0] div;
  logic [1:0] usr_mode;
  logic [7:0] usr_parallel_in;
  logic       usr_serial_left;
  logic       usr_serial_right;
  logic [7:0] usr_q;
  logic       sdi;
  logic       sdo;
  logic       bit_strobe;
  logic       busy;
  logic       done_valid;
  logic       done_ready;
  logic [7:0] done_data;

  usr_shift_sequencer #(.WIDTH(8), .CNT_W(4), .DIV_W(8)) dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .tx_data(tx_data), .dir(dir), .bit_count(bit_count), .div(div),
    .usr_mode(usr_mode), .usr_parallel_in(usr_parallel_in),
    .usr_serial_left(usr_serial_left), .usr_serial_right(usr_serial_right),
    .usr_q(usr_q), .sdi(sdi), .sdo(sdo), .bit_strobe(bit_strobe), .busy(busy),
    .done_valid(done_valid), .done_ready(done_ready), .done_data(done_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External universal shift register
  always @(posedge clk) begin
    case (usr_mode)
      2'b11:   usr_q <= usr_parallel_in;
      2'b01:   usr_q <= {usr_q[6:0], usr_serial_right};
      2'b10:   usr_q <= {usr_serial_left, usr_q[7:1]};
      default: usr_q <= usr_q;
    endcase
  end

  // sdi presents sdi_word MSB-first, advancing one bit per shift
  logic [7:0] sdi_word = 8'h00;
  logic [2:0] sdi_k = 3'd0;
  always @(posedge clk) begin
    if (start_valid && start_ready) sdi_k <= 3'd0;
    else if (bit_strobe)            sdi_k <= sdi_k + 3'd1;
  end
  assign sdi = sdi_word[3'd7 - sdi_k];

  typedef struct { int cyc; logic sdo; logic [1:0] mode; } strb_t;
  typedef struct { int cyc; logic [7:0] data; } dn_t;
  strb_t sq[$];
  dn_t   dq[$];

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  logic dv_prev = 1'b0;
  always @(negedge clk) begin
    if (bit_strobe === 1'b1) begin
      if (sq.size() == 0) begin
        check("unexpected strobe", 32'd1, 32'd0);
      end else begin
        strb_t e;
        e = sq.pop_front();
        check("strobe cycle", cyc, e.cyc);
        check("strobe sdo", {31'd0, sdo}, {31'd0, e.sdo});
        check("strobe mode", {30'd0, usr_mode}, {30'd0, e.mode});
      end
    end
    if (done_valid === 1'b1 && !dv_prev) begin
      if (dq.size() == 0) begin
        check("unexpected done", 32'd1, 32'd0);
      end else begin
        dn_t d;
        d = dq.pop_front();
        check("done cycle", cyc, d.cyc);
        check("done data", {24'd0, done_data}, {24'd0, d.data});
      end
    end
    dv_prev <= (done_valid === 1'b1);
  end

  // exp_sdo bit k is the sdo value expected at the k-th strobe
  task automatic issue(input logic [7:0] tx, input logic d, input logic [3:0] bc,
                       input logic [7:0] dv, input logic [7:0] sw, input logic [7:0] exp_sdo,
                       input logic [7:0] exp_done, input int n_exp, input bit exp_fin,
                       output int t);
    bit ok = 0;
    int n;
    @(negedge clk);
    tx_data = tx; dir = d; bit_count = bc; div = dv; sdi_word = sw; start_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (start_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    check("accept", {31'd0, ok}, 32'd1);
    t = cyc;
    n = (bc == 4'd0) ? 8 : int'(bc);
    for (int k = 0; k < n_exp; k++)
      sq.push_back('{t + 3 + int'(dv) + k * (int'(dv) + 2), exp_sdo[k], d ? 2'b10 : 2'b01});
    if (exp_fin) dq.push_back('{t + 2 + n * (int'(dv) + 2), exp_done});
    @(posedge clk);
    #1;
    // Scramble the request fields; the transfer must not notice
    start_valid = 1'b0;
    tx_data = ~tx; dir = ~d; bit_count = bc + 4'd1; div = dv + 8'd1;
  endtask

  task automatic drain(input string name);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sq.size() == 0 && dq.size() == 0 && !busy) begin ok = 1; break; end
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, rc;
    bit seen;
    reset = 1'b1; start_valid = 1'b0; tx_data = 8'h00; dir = 1'b0;
    bit_count = 4'd0; div = 8'd0; done_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst usr_mode", {30'd0, usr_mode}, 32'd0);
    check("rst parallel_in", {24'd0, usr_parallel_in}, 32'd0);
    check("rst sdo", {31'd0, sdo}, 32'd0);
    check("rst bit_strobe", {31'd0, bit_strobe}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done_valid", {31'd0, done_valid}, 32'd0);
    check("rst done_data", {24'd0, done_data}, 32'd0);
    check("rst start_ready", {31'd0, start_ready}, 32'd1);
    reset = 1'b0;

    issue(8'hA5, 1'b0, 4'd8, 8'd0, 8'h3C, 8'hA5, 8'h3C, 8, 1, t);
    drain("drain left8");
    issue(8'hF0, 1'b1, 4'd3, 8'd0, 8'hFF, 8'h00, 8'hFE, 3, 1, t);
    drain("drain right3");
    issue(8'h3D, 1'b1, 4'd2, 8'd2, 8'h00, 8'h01, 8'h0F, 2, 1, t);
    drain("drain div2");
    issue(8'h81, 1'b0, 4'd0, 8'd0, 8'h00, 8'h81, 8'h00, 8, 1, t);
    drain("drain count0");

    // Result backpressure with a request already waiting
    done_ready = 1'b0;
    issue(8'h5A, 1'b0, 4'd1, 8'd0, 8'h00, 8'h00, 8'hB4, 1, 1, t);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_valid) begin seen = 1; break; end
    end
    check("hold done seen", {31'd0, seen}, 32'd1);
    start_valid = 1'b1; tx_data = 8'h0F; dir = 1'b1; bit_count = 4'd4; div = 8'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold done_valid", {31'd0, done_valid}, 32'd1);
      check("hold done_data", {24'd0, done_data}, 32'h B4);
      check("hold start_ready", {31'd0, start_ready}, 32'd0);
    end
    done_ready = 1'b1;
    rc = cyc;
    issue(8'h0F, 1'b1, 4'd4, 8'd1, 8'h00, 8'h0F, 8'h00, 4, 1, t);
    check("accept after release", t, rc + 1);
    drain("drain after hold");

    // Reset while waiting before the third bit
    issue(8'hC3, 1'b0, 4'd8, 8'd3, 8'h00, 8'h03, 8'h00, 2, 0, t);
    while (cyc < t + 13) @(negedge clk);
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("post-reset usr_mode", {30'd0, usr_mode}, 32'd0);
    check("post-reset sdo", {31'd0, sdo}, 32'd0);
    check("post-reset busy", {31'd0, busy}, 32'd0);
    check("post-reset start_ready", {31'd0, start_ready}, 32'd1);
    check("post-reset strobes seen", sq.size(), 32'd0);
    reset = 1'b0;
    issue(8'h96, 1'b0, 4'd4, 8'd1, 8'hA0, 8'h09, 8'h6A, 4, 1, t);
    drain("drain after reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/usr_shift_sequencer.md
Name: usr_shift_sequencer

Overview:
- Controller that sequences an external 8-bit universal shift register: parallel load, hold, left shift, right shift.
- Accepts a transmit word through a valid/ready handshake and loads it into the register.
- Clocks out a programmable number of bits serially on sdo at a programmable bit interval, shifting sdi in at the same time.
- Returns the resulting register contents through a valid/ready handshake; forms a full-duplex serial engine.

Parameters:
- WIDTH, 8, data width; must equal the shift register width.
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WIDTH.
- DIV_W, 8, bit-interval divider width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start_valid  input  1  transfer request.
- start_ready  output  1  controller can accept a request.
- tx_data  input  WIDTH  word to load.
- dir  input  1  0 = left shift (MSB out first); 1 = right shift (LSB out first).
- bit_count  input  CNT_W  bits to shift, 1..WIDTH; 0 means WIDTH.
- div  input  DIV_W  extra hold cycles per bit.
- usr_mode  output  2  register mode: 00 hold, 01 left shift (serial in at LSB), 10 right shift (serial in at MSB), 11 parallel load.
- usr_parallel_in  output  WIDTH  load value.
- usr_serial_left  output  1  serial input into MSB; equals sdi.
- usr_serial_right  output  1  serial input into LSB; equals sdi.
- usr_q  input  WIDTH  current register contents.
- sdi  input  1  serial data in.
- sdo  output  1  serial data out.
- bit_strobe  output  1  high in each SHIFT cycle.
- busy  output  1  high in any state except IDLE.
- done_valid  output  1  result available.
- done_ready  input  1  consumer accepts the result.
- done_data  output  WIDTH  register contents at completion.

Behaviour:
- Reset: state returns to IDLE in the cycle after reset is sampled high, from any state. All internal registers clear.
  - Output values in reset/IDLE: usr_mode=00, usr_parallel_in=0, sdo=0, bit_strobe=0, busy=0, done_valid=0, done_data=0, start_ready=1.
- States: IDLE, LOAD, WAIT, SHIFT, DONE. Transitions:
  - IDLE: start_ready=1, usr_mode=00. On start_valid&start_ready, latch tx_data, dir, div and bit_count (0 maps to WIDTH), then go to LOAD.
  - LOAD: one cycle; usr_mode=11, usr_parallel_in=latched tx_data. Go to WAIT; divider counter = div.
  - WAIT: usr_mode=00. If divider counter == 0, go to SHIFT; otherwise decrement. WAIT lasts div+1 cycles.
  - SHIFT: one cycle; usr_mode = dir ? 10 : 01; bit_strobe=1; decrement bits remaining. If bits remaining was 1, go to DONE; otherwise go to WAIT with divider counter reloaded to div.
  - DONE: usr_mode=00, done_valid=1, done_data = usr_q, stable while done_valid=1. When done_ready=1, go to IDLE.
- start_ready is 0 outside IDLE. A start_valid asserted during DONE is accepted only in the following IDLE cycle.
- sdo:
  - In WAIT and SHIFT: sdo = dir ? usr_q[0] : usr_q[WIDTH-1], combinational from usr_q.
  - In all other states: sdo = 0.
- usr_serial_left and usr_serial_right both equal sdi combinationally. sdi is captured on the SHIFT-cycle clock edge.
- Latency:
  - With n effective bits, done_valid rises exactly 2 + n*(div+2) cycles after the acceptance edge.
  - The first bit_strobe occurs at acceptance + 3 + div.
- Bits are not wrapped: unshifted bits of tx_data remain in place in done_data.
- Changing tx_data, dir, bit_count or div mid-transfer has no effect.

Test Plan:
- tx_data=0xA5, dir=0, bit_count=8, div=0, sdi driving 0x3C MSB-first on each SHIFT -> sdo per strobe 1,0,1,0,0,1,0,1; done_valid at T+18; done_data=0x3C.
- tx_data=0xF0, dir=1, bit_count=3, div=0, sdi=1 -> sdo 0,0,0; usr_mode 10 on three strobes; done_data=0xFE at T+8.
- div=2, bit_count=2 -> bit_strobe at T+5 and T+9 only; usr_mode 00 in between; done_valid at T+10.
- bit_count=0, tx_data=0x81, dir=0, sdi=0 -> 8 strobes; done_data=0x00 at T+18.
- Hold done_ready=0 for 5 cycles with start_valid=1 -> done_valid and done_data stable, start_ready=0. Raise done_ready -> IDLE next cycle; new request accepted that cycle.
- Assert reset during WAIT of bit 3 -> next cycle: IDLE, usr_mode=00, sdo=0, busy=0, start_ready=1. A new transfer then completes normally.
